mem_ctrl: RTL

- Memory-bus controller directly downstream of the Hack CPU core.
- Services the CPU data port: address, write strobe, write data, read data and busy.
- Decodes the Hack memory map into three regions: RAM (0x0000-0x3FFF), screen framebuffer (0x4000-0x5FFF) and keyboard register (0x6000).
- Runs req/ack handshakes to the RAM and screen back ends, and stalls the CPU via cpu_busy until read data for the current address is valid.

---
 rtl/mem_map_pkg.sv | 9 +
 rtl/mem_decode.sv | 28 ++
 rtl/mem_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// Hack memory map shared by the bus controller, the screen and the ROM loader.
package mem_map_pkg;
  typedef enum logic [1:0] {REG_RAM, REG_SCREEN, REG_KBD, REG_NONE} region_t;
  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ} state_t;

  localparam logic [15:0] RAM_LIMIT   = 16'h3FFF;
  localparam logic [15:0] SCREEN_BASE = 16'h4000;
  localparam logic [15:0] KBD_ADDR    = 16'h6000;
endpackage

// File: rtl/mem_decode.sv
// Combinational Hack address decode: region plus word offset within that region.
module mem_decode
  import mem_map_pkg::*;
#(
  parameter logic [15:0] SCREEN_BASE = mem_map_pkg::SCREEN_BASE,
  parameter logic [15:0] KBD_ADDR    = mem_map_pkg::KBD_ADDR
) (
  input  logic [15:0] addr,
  output region_t     region,
  output logic [13:0] offset
);
  logic [15:0] scr_off;

  assign scr_off = addr - SCREEN_BASE;

  always_comb begin
    region = REG_NONE;
    offset = addr[13:0];
    if (addr <= RAM_LIMIT) begin
      region = REG_RAM;
    end else if (addr >= SCREEN_BASE && addr < KBD_ADDR) begin
      region = REG_SCREEN;
      offset = {1'b0, scr_off[12:0]};
    end else if (addr == KBD_ADDR) begin
      region = REG_KBD;
    end
  end
endmodule

// File: rtl/mem_ctrl.sv
// Hack CPU data-port controller: decodes RAM/screen/keyboard and runs req/ack
// handshakes to the back ends, stalling the CPU until read data is current.
//
// state  | meaning
// IDLE   | no back-end request; serves keyboard/out-of-range reads, accepts writes
// RD_REQ | read request outstanding to RAM or screen
// WR_REQ | write request outstanding to RAM or screen
module mem_ctrl
  import mem_map_pkg::*;
#(
  parameter int          TIMEOUT     = 255,
  parameter logic [15:0] SCREEN_BASE = mem_map_pkg::SCREEN_BASE,
  parameter logic [15:0] KBD_ADDR    = mem_map_pkg::KBD_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_busy,
  output logic        ram_req,
  output logic        ram_we,
  output logic [13:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic        ram_ack,
  output logic        scr_req,
  output logic        scr_we,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_wdata,
  input  logic [15:0] scr_rdata,
  input  logic        scr_ack,
  input  logic [15:0] kbd_code,
  output logic        bus_error
);
  localparam int CNT_W = 16;

  state_t       state;
  region_t      region;
  logic [13:0]  offset;
  logic         rd_valid;
  logic [15:0]  rd_addr;
  logic [15:0]  rd_data;
  logic [15:0]  kbd_q;
  logic [13:0]  addr_q;
  logic [15:0]  wdata_q;
  logic         we_q;
  logic [CNT_W-1:0] cnt;
  logic         stale;
  logic         ack;
  logic [15:0]  be_rdata;

  mem_decode #(.SCREEN_BASE(SCREEN_BASE), .KBD_ADDR(KBD_ADDR)) u_decode (
    .addr   (cpu_address),
    .region (region),
    .offset (offset)
  );

  assign stale     = !rd_valid || (cpu_address != rd_addr);
  assign cpu_busy  = (state != IDLE) || stale;
  assign cpu_rdata = (rd_addr == KBD_ADDR) ? kbd_q : rd_data;

  assign ram_addr  = addr_q;
  assign scr_addr  = addr_q[12:0];
  assign ram_wdata = wdata_q;
  assign scr_wdata = wdata_q;
  assign ram_we    = ram_req && we_q;
  assign scr_we    = scr_req && we_q;

  // Only the region with req raised can complete; stray acks are ignored.
  assign ack      = (ram_req && ram_ack) || (scr_req && scr_ack);
  assign be_rdata = ram_req ? ram_rdata : scr_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ram_req   <= 1'b0;
      scr_req   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
      kbd_q     <= '0;
      bus_error <= 1'b0;
      cnt       <= '0;
    end else begin
      kbd_q <= kbd_code;
      case (state)
        IDLE: begin
          if (stale) begin
            rd_addr <= cpu_address;
            case (region)
              REG_RAM, REG_SCREEN: begin
                ram_req <= (region == REG_RAM);
                scr_req <= (region == REG_SCREEN);
                we_q    <= 1'b0;
                addr_q  <= offset;
                state   <= RD_REQ;
              end
              REG_KBD: rd_valid <= 1'b1;
              default: begin
                rd_data  <= '0;
                rd_valid <= 1'b1;
              end
            endcase
          end else if (cpu_write && (region == REG_RAM || region == REG_SCREEN)) begin
            ram_req  <= (region == REG_RAM);
            scr_req  <= (region == REG_SCREEN);
            we_q     <= 1'b1;
            addr_q   <= offset;
            wdata_q  <= cpu_wdata;
            rd_valid <= 1'b0;
            state    <= WR_REQ;
          end
        end
        RD_REQ, WR_REQ: begin
          // Ack beats timeout; req stays high for exactly TIMEOUT cycles otherwise.
          if (ack || cnt == CNT_W'(TIMEOUT - 1)) begin
            ram_req <= 1'b0;
            scr_req <= 1'b0;
            we_q    <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
            if (!ack) bus_error <= 1'b1;
            if (state == RD_REQ) begin
              rd_data  <= ack ? be_rdata : 16'h0000;
              rd_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
